// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer arbiter: turns splitter packets into addressed pixel writes, queues them
// in a small FIFO and interleaves them with fixed-latency display reads on one BRAM port.
module frame_buffer_arbiter #(
  parameter int ADDR_WIDTH        = 17,
  parameter int FIFO_DEPTH        = 8,
  parameter int PIXELS_PER_PACKET = 320
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          addr_axiov,
  input  logic [23:0]                   addr,
  input  logic                          pixel_axiov,
  input  logic [7:0]                    pixel,
  input  logic                          rd_req,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic [7:0]                    mem_wdata,
  input  logic [7:0]                    mem_rdata,
  output logic                          packet_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(PIXELS_PER_PACKET + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS_PER_PACKET);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_ACTIVE} trk_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            data;
  } wr_cmd_t;

  trk_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDX_W-1:0]      r_idx;

  wr_cmd_t               r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [1:0]            r_rd_pipe;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_idx_next;
  wr_cmd_t               w_push_cmd;
  wr_cmd_t               w_head;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_done;
  logic                  w_unused_addr;

  // A same-cycle address strobe takes effect before the pixel, so the pixel lands at idx 0.
  assign w_accept   = pixel_axiov && (addr_axiov || (r_state == ST_ACTIVE));
  assign w_base     = addr_axiov ? addr[ADDR_WIDTH-1:0] : r_base;
  assign w_idx      = addr_axiov ? '0 : r_idx;
  assign w_idx_next = w_idx + IDX_W'(w_accept);
  assign w_push_cmd = '{addr: w_base + ADDR_WIDTH'(w_idx), data: pixel};
  assign w_done     = w_accept && (w_idx_next == IDX_LAST);

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = !rd_req && !w_empty;
  assign w_push     = w_accept && (!w_full || w_pop);
  assign w_drop     = w_accept && !w_push;
  assign w_head     = r_mem[r_rd_ptr];

  assign fifo_count    = r_count;
  assign w_unused_addr = ^addr[23:ADDR_WIDTH];

  // NOTE: every register below uses <= so all blocks see pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_idx       <= '0;
      packet_done <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      packet_done <= w_done;
      if (w_drop) overflow <= 1'b1;
      if (addr_axiov) r_base <= addr[ADDR_WIDTH-1:0];
      // Dropped pixels still advance idx so later pixels keep their addresses.
      if (addr_axiov || w_accept) r_idx <= w_idx_next;
      case (r_state)
        ST_IDLE:   if (addr_axiov && !w_done) r_state <= ST_ACTIVE;
        ST_ACTIVE: if (w_done) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Reads always win the port; writes only drain in cycles with no read request.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      r_rd_pipe <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      mem_we <= w_pop;
      if (rd_req) begin
        mem_addr <= rd_addr;
      end else if (!w_empty) begin
        mem_addr  <= w_head.addr;
        mem_wdata <= w_head.data;
      end
      r_rd_pipe <= {r_rd_pipe[0], rd_req};
      rd_valid  <= r_rd_pipe[1];
      if (r_rd_pipe[1]) rd_data <= mem_rdata;
    end
  end

endmodule
